// File: rtl/uart_pkg.sv
// Shared definitions for the byte-level UART receiver.
// Latency: n/a (types, constants and a helper function only).
// Backpressure: n/a.
package uart_pkg;

  // Bit positions of the fields inside i_setup.
  localparam int SETUP_BAUD_MSB = 23;
  localparam int SETUP_PAR_EN   = 24;
  localparam int SETUP_PAR_ODD  = 25;

  localparam int CNT_W            = SETUP_BAUD_MSB + 1;
  localparam int CLKS_MIN_DEFAULT = 4;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP,
    ST_WAIT_IDLE
  } rx_state_t;

  // Line configuration captured on the start edge of each frame.
  typedef struct packed {
    logic             par_odd;
    logic             par_en;
    logic [CNT_W-1:0] baud;
  } rx_cfg_t;

  // Very small divisors cannot place a mid-bit sample; raise them to the floor.
  function automatic logic [CNT_W-1:0] clamp_baud(input logic [CNT_W-1:0] b,
                                                 input logic [CNT_W-1:0] lo);
    return (b < lo) ? lo : b;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Generic two-flop synchroniser for a single asynchronous input.
// Latency: 2 i_clk cycles from input to o_q.
// Backpressure: none; free-running.
// Ports: i_clk clock, n_rst async active-low reset (flops load RST_VAL),
//        i_d asynchronous input, o_q synchronised output.
module sync_2ff #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic i_clk,
  input  logic n_rst,
  input  logic i_d,
  output logic o_q
);

  logic meta;

  always_ff @(posedge i_clk or negedge n_rst) begin
    if (!n_rst) begin
      meta <= RST_VAL;
      o_q  <= RST_VAL;
    end else begin
      meta <= i_d;
      o_q  <= meta;
    end
  end

endmodule

// File: rtl/uart_byte_rx.sv
// UART byte receiver: 8 data bits, optional odd/even parity, one stop bit.
// Latency: o_wr pulses one cycle after the stop-bit sample.
// Backpressure: none; every o_wr must be consumed by the downstream block.
// Ports: i_clk clock, n_btn_rst async active-low reset, i_setup baud/parity config,
//        i_uart_rx raw line (idle high), o_wr byte strobe, o_data byte,
//        o_frame_err / o_parity_err (valid with o_wr), o_break level.
module uart_byte_rx
  import uart_pkg::*;
#(
  parameter int CLKS_MIN = CLKS_MIN_DEFAULT
) (
  input  logic        i_clk,
  input  logic        n_btn_rst,
  input  logic [30:0] i_setup,
  input  logic        i_uart_rx,
  output logic        o_wr,
  output logic [7:0]  o_data,
  output logic        o_frame_err,
  output logic        o_parity_err,
  output logic        o_break
);

  localparam logic [CNT_W-1:0] CLKS_MIN_V = CNT_W'(CLKS_MIN);

  logic rx_s;

  sync_2ff #(.RST_VAL(1'b1)) u_sync (
    .i_clk (i_clk),
    .n_rst (n_btn_rst),
    .i_d   (i_uart_rx),
    .o_q   (rx_s)
  );

  // Reserved setup bits are deliberately ignored.
  logic unused_setup;
  assign unused_setup = ^i_setup[30:26];

  rx_state_t        state, state_nxt;
  rx_cfg_t          cfg, cfg_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [7:0]       shreg, shreg_nxt;
  logic [2:0]       bit_idx, bit_idx_nxt;
  logic             par_bit, par_bit_nxt;
  logic             par_err, par_err_nxt;
  logic             wr_nxt, frame_err_nxt, parity_err_nxt, break_nxt;
  logic [7:0]       data_nxt;
  logic [CNT_W-1:0] baud_in;
  logic             expired;

  assign baud_in = clamp_baud(i_setup[SETUP_BAUD_MSB:0], CLKS_MIN_V);
  assign expired = (cnt == '0);

  always_ff @(posedge i_clk or negedge n_btn_rst) begin
    if (!n_btn_rst) begin
      state        <= ST_IDLE;
      cfg          <= '{par_odd: 1'b0, par_en: 1'b0, baud: CLKS_MIN_V};
      cnt          <= '0;
      shreg        <= '0;
      bit_idx      <= '0;
      par_bit      <= 1'b0;
      par_err      <= 1'b0;
      o_wr         <= 1'b0;
      o_data       <= '0;
      o_frame_err  <= 1'b0;
      o_parity_err <= 1'b0;
      o_break      <= 1'b0;
    end else begin
      state        <= state_nxt;
      cfg          <= cfg_nxt;
      cnt          <= cnt_nxt;
      shreg        <= shreg_nxt;
      bit_idx      <= bit_idx_nxt;
      par_bit      <= par_bit_nxt;
      par_err      <= par_err_nxt;
      o_wr         <= wr_nxt;
      o_data       <= data_nxt;
      o_frame_err  <= frame_err_nxt;
      o_parity_err <= parity_err_nxt;
      o_break      <= break_nxt;
    end
  end

  always_comb begin
    state_nxt      = state;
    cfg_nxt        = cfg;
    cnt_nxt        = cnt;
    shreg_nxt      = shreg;
    bit_idx_nxt    = bit_idx;
    par_bit_nxt    = par_bit;
    par_err_nxt    = par_err;
    wr_nxt         = 1'b0;
    data_nxt       = o_data;
    frame_err_nxt  = o_frame_err;
    parity_err_nxt = o_parity_err;
    break_nxt      = o_break;

    // Every bit-timed state counts down and acts only on expiry.
    if (state != ST_IDLE && state != ST_WAIT_IDLE && !expired) begin
      cnt_nxt = cnt - 1'b1;
    end

    unique case (state)
      ST_IDLE: begin
        if (!rx_s) begin
          // Config is frozen here so mid-frame setup writes cannot corrupt the frame.
          cfg_nxt.baud    = baud_in;
          cfg_nxt.par_en  = i_setup[SETUP_PAR_EN];
          cfg_nxt.par_odd = i_setup[SETUP_PAR_ODD];
          cnt_nxt         = (baud_in >> 1) - 1'b1;
          state_nxt       = ST_START;
        end
      end
      ST_START: begin
        if (expired) begin
          if (rx_s) begin
            state_nxt = ST_IDLE;            // line back high at mid-bit: glitch
          end else begin
            cnt_nxt     = cfg.baud - 1'b1;
            bit_idx_nxt = '0;
            state_nxt   = ST_DATA;
          end
        end
      end
      ST_DATA: begin
        if (expired) begin
          shreg_nxt = {rx_s, shreg[7:1]};   // LSB arrives first
          cnt_nxt   = cfg.baud - 1'b1;
          if (bit_idx == 3'd7) begin
            state_nxt = cfg.par_en ? ST_PARITY : ST_STOP;
          end else begin
            bit_idx_nxt = bit_idx + 3'd1;
          end
        end
      end
      ST_PARITY: begin
        if (expired) begin
          par_bit_nxt = rx_s;
          par_err_nxt = ((^shreg) ^ rx_s) != cfg.par_odd;
          cnt_nxt     = cfg.baud - 1'b1;
          state_nxt   = ST_STOP;
        end
      end
      ST_STOP: begin
        if (expired) begin
          wr_nxt         = 1'b1;
          data_nxt       = shreg;
          frame_err_nxt  = !rx_s;
          parity_err_nxt = cfg.par_en & par_err;
          if (rx_s) begin
            state_nxt = ST_IDLE;
          end else begin
            // An all-zero character with a low stop bit means the line is held low.
            if (shreg == 8'h00 && !(cfg.par_en && par_bit)) begin
              break_nxt = 1'b1;
            end
            state_nxt = ST_WAIT_IDLE;
          end
        end
      end
      ST_WAIT_IDLE: begin
        if (rx_s) begin
          break_nxt = 1'b0;
          state_nxt = ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_uart_byte_rx.sv
// Directed self-checking bench for uart_byte_rx.
module tb_uart_byte_rx;

  logic        i_clk = 1'b0;
  logic        n_btn_rst = 1'b0;
  logic [30:0] i_setup;
  logic        i_uart_rx = 1'b1;
  logic        o_wr;
  logic [7:0]  o_data;
  logic        o_frame_err;
  logic        o_parity_err;
  logic        o_break;

  int n_cmp  = 0;
  int n_fail = 0;
  int cyc    = 0;

  typedef struct {
    int         t;
    logic [7:0] d;
    logic       fe;
    logic       pe;
    logic       brk;
  } ev_t;
  ev_t evq[$];

  uart_byte_rx dut (
    .i_clk        (i_clk),
    .n_btn_rst    (n_btn_rst),
    .i_setup      (i_setup),
    .i_uart_rx    (i_uart_rx),
    .o_wr         (o_wr),
    .o_data       (o_data),
    .o_frame_err  (o_frame_err),
    .o_parity_err (o_parity_err),
    .o_break      (o_break)
  );

  always #5 i_clk = ~i_clk;

  always @(posedge i_clk) cyc++;

  always @(negedge i_clk) begin
    if (o_wr === 1'b1) evq.push_back('{cyc, o_data, o_frame_err, o_parity_err, o_break});
  end

  function automatic logic [30:0] mk_setup(input int b, input bit en, input bit odd);
    return {5'b10101, odd, en, 24'(b)};
  endfunction

  task automatic tick(input int n);
    repeat (n) @(posedge i_clk);
    #1;
  endtask

  // Drives one frame, b clocks per bit; t0 is the cycle count when the start bit begins.
  task automatic send_frame(input logic [7:0] d, input int b, input bit par_en,
                            input logic par_bit, input logic stop_bit, output int t0);
    logic [7:0] dv;
    dv = d;
    t0 = cyc;
    i_uart_rx = 1'b0;
    tick(b);
    for (int i = 0; i < 8; i++) begin
      i_uart_rx = dv[i];
      tick(b);
    end
    if (par_en) begin
      i_uart_rx = par_bit;
      tick(b);
    end
    i_uart_rx = stop_bit;
    tick(b);
  endtask

  // Strobe seen at negedge after posedge t0 + 3 + B/2 + 9B (+B with parity).
  function automatic int exp_t(input int t0, input int b, input bit par);
    return t0 + 3 + b / 2 + 9 * b + (par ? b : 0);
  endfunction

  task automatic test_reset;
    i_setup   = mk_setup(16, 0, 0);
    n_btn_rst = 1'b0;
    tick(3);
    n_cmp++; if (o_wr !== 1'b0) begin n_fail++; $display("FAIL reset_wr: got %b want 0", o_wr); end
    n_cmp++; if (o_data !== 8'h00) begin n_fail++; $display("FAIL reset_data: got %h want 00", o_data); end
    n_cmp++; if (o_frame_err !== 1'b0) begin n_fail++; $display("FAIL reset_fe: got %b want 0", o_frame_err); end
    n_cmp++; if (o_parity_err !== 1'b0) begin n_fail++; $display("FAIL reset_pe: got %b want 0", o_parity_err); end
    n_cmp++; if (o_break !== 1'b0) begin n_fail++; $display("FAIL reset_brk: got %b want 0", o_break); end
    n_btn_rst = 1'b1;
    tick(5);
  endtask

  task automatic test_basic;
    int t0;
    evq.delete();
    i_setup = mk_setup(16, 0, 0);
    send_frame(8'hA5, 16, 0, 1'b0, 1'b1, t0);
    tick(8);
    n_cmp++; if (evq.size() !== 1) begin n_fail++; $display("FAIL basic_count: got %0d want 1", evq.size()); end
    if (evq.size() > 0) begin
      n_cmp++; if (evq[0].t !== exp_t(t0, 16, 0)) begin n_fail++; $display("FAIL basic_time: got %0d want %0d", evq[0].t, exp_t(t0, 16, 0)); end
      n_cmp++; if (evq[0].d !== 8'hA5) begin n_fail++; $display("FAIL basic_data: got %h want a5", evq[0].d); end
      n_cmp++; if (evq[0].fe !== 1'b0 || evq[0].pe !== 1'b0) begin n_fail++; $display("FAIL basic_errs: got fe=%b pe=%b want 0 0", evq[0].fe, evq[0].pe); end
    end
  endtask

  task automatic test_back_to_back;
    int t0, t1, t2;
    logic [7:0] exp_d [3];
    exp_d = '{8'h00, 8'hFF, 8'h3C};
    evq.delete();
    i_setup = mk_setup(16, 0, 0);
    send_frame(8'h00, 16, 0, 1'b0, 1'b1, t0);
    fork
      send_frame(8'hFF, 16, 0, 1'b0, 1'b1, t1);
      begin
        tick(40);
        i_setup = mk_setup(40, 1, 1);   // mid-frame: must not disturb byte 2
        tick(110);
        i_setup = mk_setup(16, 0, 0);
      end
    join
    send_frame(8'h3C, 16, 0, 1'b0, 1'b1, t2);
    tick(8);
    n_cmp++; if (evq.size() !== 3) begin n_fail++; $display("FAIL b2b_count: got %0d want 3", evq.size()); end
    if (evq.size() == 3) begin
      for (int i = 0; i < 3; i++) begin
        n_cmp++; if (evq[i].d !== exp_d[i]) begin n_fail++; $display("FAIL b2b_data%0d: got %h want %h", i, evq[i].d, exp_d[i]); end
      end
      n_cmp++; if (evq[0].t !== exp_t(t0, 16, 0)) begin n_fail++; $display("FAIL b2b_time0: got %0d want %0d", evq[0].t, exp_t(t0, 16, 0)); end
      n_cmp++; if (evq[1].t - evq[0].t !== 160) begin n_fail++; $display("FAIL b2b_gap01: got %0d want 160", evq[1].t - evq[0].t); end
      n_cmp++; if (evq[2].t - evq[1].t !== 160) begin n_fail++; $display("FAIL b2b_gap12: got %0d want 160", evq[2].t - evq[1].t); end
    end
  endtask

  task automatic test_parity;
    int t0, t1;
    evq.delete();
    i_setup = mk_setup(20, 1, 1);
    send_frame(8'h01, 20, 1, 1'b0, 1'b1, t0);   // one data 1 + parity 0: odd, good
    send_frame(8'h01, 20, 1, 1'b1, 1'b1, t1);   // even count of ones: bad
    tick(8);
    n_cmp++; if (evq.size() !== 2) begin n_fail++; $display("FAIL par_count: got %0d want 2", evq.size()); end
    if (evq.size() == 2) begin
      n_cmp++; if (evq[0].t !== exp_t(t0, 20, 1)) begin n_fail++; $display("FAIL par_time: got %0d want %0d", evq[0].t, exp_t(t0, 20, 1)); end
      n_cmp++; if (evq[0].pe !== 1'b0) begin n_fail++; $display("FAIL par_good: got pe=%b want 0", evq[0].pe); end
      n_cmp++; if (evq[1].pe !== 1'b1) begin n_fail++; $display("FAIL par_bad: got pe=%b want 1", evq[1].pe); end
      n_cmp++; if (evq[1].d !== 8'h01 || evq[1].fe !== 1'b0) begin n_fail++; $display("FAIL par_data: got %h fe=%b want 01 fe=0", evq[1].d, evq[1].fe); end
    end
  endtask

  task automatic test_frame_err;
    int t0, t1, t2;
    evq.delete();
    i_setup = mk_setup(16, 0, 0);
    send_frame(8'h55, 16, 0, 1'b0, 1'b0, t0);
    // Start bit continues the low stop bit, so no fresh falling edge: frame ignored.
    send_frame(8'hFF, 16, 0, 1'b0, 1'b1, t1);
    tick(8);
    n_cmp++; if (evq.size() !== 1) begin n_fail++; $display("FAIL fe_count: got %0d want 1", evq.size()); end
    if (evq.size() > 0) begin
      n_cmp++; if (evq[0].d !== 8'h55 || evq[0].fe !== 1'b1) begin n_fail++; $display("FAIL fe_flag: got %h fe=%b want 55 fe=1", evq[0].d, evq[0].fe); end
      n_cmp++; if (evq[0].brk !== 1'b0) begin n_fail++; $display("FAIL fe_nobrk: got %b want 0", evq[0].brk); end
    end
    evq.delete();
    send_frame(8'h12, 16, 0, 1'b0, 1'b1, t2);
    tick(8);
    n_cmp++; if (evq.size() !== 1) begin n_fail++; $display("FAIL fe_recover_count: got %0d want 1", evq.size()); end
    if (evq.size() > 0) begin
      n_cmp++; if (evq[0].d !== 8'h12 || evq[0].fe !== 1'b0) begin n_fail++; $display("FAIL fe_recover: got %h fe=%b want 12 fe=0", evq[0].d, evq[0].fe); end
    end
  endtask

  task automatic test_break;
    int t0;
    evq.delete();
    i_setup   = mk_setup(16, 0, 0);
    t0        = cyc;
    i_uart_rx = 1'b0;
    tick(30 * 16);
    n_cmp++; if (o_break !== 1'b1) begin n_fail++; $display("FAIL brk_held: got %b want 1", o_break); end
    n_cmp++; if (evq.size() !== 1) begin n_fail++; $display("FAIL brk_count: got %0d want 1", evq.size()); end
    if (evq.size() > 0) begin
      n_cmp++; if (evq[0].d !== 8'h00 || evq[0].fe !== 1'b1 || evq[0].brk !== 1'b1) begin n_fail++; $display("FAIL brk_event: got %h fe=%b brk=%b want 00 1 1", evq[0].d, evq[0].fe, evq[0].brk); end
      n_cmp++; if (evq[0].t !== exp_t(t0, 16, 0)) begin n_fail++; $display("FAIL brk_time: got %0d want %0d", evq[0].t, exp_t(t0, 16, 0)); end
    end
    i_uart_rx = 1'b1;
    tick(5);
    n_cmp++; if (o_break !== 1'b0) begin n_fail++; $display("FAIL brk_clear: got %b want 0", o_break); end
    n_cmp++; if (evq.size() !== 1) begin n_fail++; $display("FAIL brk_extra: got %0d want 1", evq.size()); end
    tick(10);
  endtask

  task automatic test_glitch;
    int t0;
    evq.delete();
    i_setup   = mk_setup(16, 0, 0);
    i_uart_rx = 1'b0;
    tick(3);
    i_uart_rx = 1'b1;
    tick(40);
    n_cmp++; if (evq.size() !== 0) begin n_fail++; $display("FAIL glitch_nowr: got %0d want 0", evq.size()); end
    send_frame(8'h5A, 16, 0, 1'b0, 1'b1, t0);
    tick(8);
    n_cmp++; if (evq.size() !== 1 || o_data !== 8'h5A) begin n_fail++; $display("FAIL glitch_idle: got n=%0d data=%h want 1 5a", evq.size(), o_data); end
  endtask

  task automatic test_clamp;
    int t0;
    evq.delete();
    i_setup = mk_setup(1, 0, 0);
    send_frame(8'hC3, 4, 0, 1'b0, 1'b1, t0);
    tick(8);
    n_cmp++; if (evq.size() !== 1) begin n_fail++; $display("FAIL clamp_count: got %0d want 1", evq.size()); end
    if (evq.size() > 0) begin
      n_cmp++; if (evq[0].d !== 8'hC3) begin n_fail++; $display("FAIL clamp_data: got %h want c3", evq[0].d); end
      n_cmp++; if (evq[0].t !== exp_t(t0, 4, 0)) begin n_fail++; $display("FAIL clamp_time: got %0d want %0d", evq[0].t, exp_t(t0, 4, 0)); end
    end
  endtask

  task automatic test_reset_mid;
    int t0;
    evq.delete();
    i_setup   = mk_setup(16, 0, 0);
    // Partial 0xF0: start + four low bits, then reset in the middle of bit 4.
    i_uart_rx = 1'b0;
    tick(16 + 4 * 16);
    i_uart_rx = 1'b1;
    tick(8);
    n_btn_rst = 1'b0;
    tick(2);
    n_cmp++; if (o_wr !== 1'b0 || o_data !== 8'h00) begin n_fail++; $display("FAIL rstmid_wr_data: got wr=%b data=%h want 0 00", o_wr, o_data); end
    n_cmp++; if (o_frame_err !== 1'b0 || o_parity_err !== 1'b0 || o_break !== 1'b0) begin n_fail++; $display("FAIL rstmid_flags: got fe=%b pe=%b brk=%b want 0 0 0", o_frame_err, o_parity_err, o_break); end
    tick(1);
    n_btn_rst = 1'b1;
    tick(5 * 16);
    send_frame(8'h7E, 16, 0, 1'b0, 1'b1, t0);
    tick(8);
    n_cmp++; if (evq.size() !== 1) begin n_fail++; $display("FAIL rstmid_count: got %0d want 1", evq.size()); end
    if (evq.size() > 0) begin
      n_cmp++; if (evq[0].d !== 8'h7E || evq[0].fe !== 1'b0) begin n_fail++; $display("FAIL rstmid_data: got %h fe=%b want 7e 0", evq[0].d, evq[0].fe); end
    end
  endtask

  initial begin
    i_setup = mk_setup(16, 0, 0);
    test_reset();
    test_basic();
    test_back_to_back();
    test_parity();
    test_frame_err();
    test_break();
    test_glitch();
    test_clamp();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_byte_rx.md
# uart_byte_rx

Byte-level UART receiver that sits directly upstream of the packet aggregator in the graphics pipeline. It synchronises the raw `i_uart_rx` pin, recovers 8-bit characters using the baud divisor carried in `i_setup`, and emits one single-cycle strobe per received byte. It also reports framing errors, parity errors and line breaks, so the aggregator can discard corrupted packets.

## Interface
Parameters:
- `CLKS_MIN`, 4: minimum accepted clocks-per-baud; smaller divisors are clamped to this value.

Ports:
- `i_clk`  in  1  the only clock.
- `n_btn_rst`  in  1  asynchronous, active-low reset.
- `i_setup`  in  31  line configuration:
  - [23:0] clocks per baud `B`.
  - [24] parity enable.
  - [25] odd parity (1) or even parity (0).
  - [30:26] reserved, ignored.
- `i_uart_rx`  in  1  raw serial line; idle high; asynchronous to `i_clk`.
- `o_wr`  out  1  one-cycle strobe: a byte is complete.
- `o_data`  out  8  received byte; LSB first on the wire; holds its value until the next `o_wr`.
- `o_frame_err`  out  1  stop bit sampled low; valid with `o_wr`.
- `o_parity_err`  out  1  parity mismatch; valid with `o_wr`; always 0 when parity is disabled.
- `o_break`  out  1  level; high while a break condition persists.

## Operation
- **Input synchroniser.** Two-flop chain on `i_uart_rx`. Both flops reset to 1. All decisions use the synchronised value `rx_s`.
- **Setup latching.** `B`, parity enable and odd-parity are latched only in IDLE, on the start edge. Changes to `i_setup` mid-frame do not affect the frame in progress. A latched `B` below `CLKS_MIN` is replaced by `CLKS_MIN`.
- **State machine.** States: IDLE, START, DATA, PARITY, STOP, WAIT_IDLE.
  - IDLE → START when `rx_s` = 0. The baud counter is loaded with floor(B/2)−1.
  - START: when the counter reaches 0, sample `rx_s`.
    - If 1 (glitch), go to IDLE with no output.
    - If 0, reload the counter with B−1 and go to DATA.
  - DATA: sample one bit per counter expiry into a shift register, LSB first. After the 8th bit go to PARITY if parity is enabled, otherwise to STOP.
  - PARITY: sample one bit. `parity_err` = XOR(data, sampled bit) ≠ odd-parity flag. Then go to STOP.
  - STOP: sample one bit.
    - Pulse `o_wr` on the next cycle, with `o_data`, `o_frame_err` and `o_parity_err` updated in that same cycle.
    - If the stop bit is 1, go to IDLE.
    - If the stop bit is 0, set `o_frame_err`. If the data is also 0x00 (and parity, if enabled, was 0), set `o_break`. Go to WAIT_IDLE.
  - WAIT_IDLE: stay until `rx_s` = 1, then clear `o_break` and go to IDLE.
- **Baud counter.** 24-bit down-counter; it expires on the cycle it equals 0. No frame needs more than 24 bits of count.
- **Reset mid-frame.** State returns to IDLE immediately and the partial byte is discarded. All outputs return to their reset values.

## Timing
- **Reset values:**
  - `o_wr` = 0, `o_data` = 0x00, `o_frame_err` = 0, `o_parity_err` = 0, `o_break` = 0.
  - State is IDLE and the synchroniser flops are 1.
- **Falling edge** first captured by flop 1 at cycle 0: `rx_s` goes low at cycle 2.
- **Sample points:**
  - Start-bit sample at cycle 2 + floor(B/2).
  - Data bit n (0–7) sampled at start-sample + (n+1)·B.
  - Parity sample at start-sample + 9·B.
  - Stop sample at start-sample + 9·B without parity, or + 10·B with parity.
- **Latency.** `o_wr` is high exactly one cycle, at stop-sample + 1.
- **Back-to-back frames.** A start bit immediately after a good stop bit is detected. IDLE is re-entered at stop-sample + 1, which is before the next start edge can be seen at `rx_s`.
- **No handshake.** The downstream aggregator must accept every `o_wr`; there is no back-pressure.

## Structure
- **Package `uart_pkg`:**
  - State enum `rx_state_t`.
  - `i_setup` field positions: `SETUP_BAUD_MSB` = 23, `SETUP_PAR_EN` = 24, `SETUP_PAR_ODD` = 25.
  - `CLKS_MIN` default.
- **Sub-module `sync_2ff`:** a generic two-flop synchroniser with a reset-value parameter. It is reused later for button inputs.

## Test plan
- **Basic receive.** B = 16, no parity, send 0xA5 → one `o_wr` at start-sample + 145 with `o_data` = 0xA5 and both error outputs 0.
- **Back-to-back and mid-frame setup change.** Send 0x00, 0xFF, 0x3C back-to-back at B = 16 → exactly three `o_wr` pulses, 160 cycles apart, with correct data. Change `i_setup` during the second byte; the second byte must still decode correctly.
- **Parity.** Odd parity, B = 20:
  - Send 0x01 with parity bit 0 → `o_parity_err` = 0.
  - Send 0x01 with parity bit 1 → `o_parity_err` = 1.
- **Framing error and break.**
  - 0x55 with stop bit forced low → `o_wr`, `o_frame_err` = 1, `o_break` = 0, and the next frame is ignored until the line returns high.
  - Line held low for 30·B → `o_data` = 0x00, `o_frame_err` = 1, and `o_break` high until the line returns high.
- **Glitch and clamp.**
  - A 3-cycle low pulse at B = 16 → no `o_wr`, return to IDLE.
  - B = 1 → behaves as B = 4; 0xC3 is received correctly.
- **Reset mid-frame.** Assert `n_btn_rst` during data bit 4, release, then send 0x7E → all outputs 0 during reset; only one `o_wr`, carrying 0x7E.
